// File: rtl/aes_decipher_ctrl_pkg.sv
// rtl/aes_decipher_ctrl_pkg.sv - shared AES round counts, key length and update-type codes
package aes_decipher_ctrl_pkg;

    // Round counts Nr per key length
    localparam logic [3:0] AES128_ROUNDS = 4'ha;
    localparam logic [3:0] AES256_ROUNDS = 4'he;

    // Key length select
    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    // Datapath operation select, shared with the round datapath and encipher controller
    localparam logic [2:0] UPD_NO_UPDATE = 3'd0;
    localparam logic [2:0] UPD_INIT      = 3'd1;
    localparam logic [2:0] UPD_SHIFT     = 3'd2;
    localparam logic [2:0] UPD_SBOX      = 3'd3;
    localparam logic [2:0] UPD_MAIN      = 3'd4;
    localparam logic [2:0] UPD_FINAL     = 3'd5;

    function automatic logic [3:0] num_rounds(input logic keylen);
        return (keylen == KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;
    endfunction

endpackage

// File: rtl/aes_decipher_ctrl.sv
// rtl/aes_decipher_ctrl.sv - sequencing FSM for the AES decipher round datapath
module aes_decipher_ctrl
    import aes_decipher_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       next,
    input  logic       keylen,
    output logic [3:0] round_key_addr,
    output logic [2:0] update_type,
    output logic [1:0] sword_ctr,
    output logic       block_we,
    output logic       ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_SBOX  = 3'd3,
        S_MAIN  = 3'd4,
        S_FINAL = 3'd5
    } state_t;

    state_t     state;
    logic [3:0] round_ctr;
    logic [1:0] sword_ctr_reg;
    logic       keylen_reg;
    logic       ready_reg;

    // Round sequencing: counters, captured key length and ready flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            round_ctr     <= 4'd0;
            sword_ctr_reg <= 2'd0;
            keylen_reg    <= KEYLEN_128;
            ready_reg     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (next) begin
                        round_ctr  <= num_rounds(keylen);
                        keylen_reg <= keylen;
                        ready_reg  <= 1'b0;
                        state      <= S_INIT;
                    end
                end
                S_INIT: begin
                    // Equals round_ctr-1; taken from the captured key length
                    round_ctr     <= num_rounds(keylen_reg) - 4'd1;
                    sword_ctr_reg <= 2'd0;
                    state         <= S_SHIFT;
                end
                S_SHIFT: begin
                    state <= S_SBOX;
                end
                S_SBOX: begin
                    // Wraps 3->0 so the next SBOX run starts on word 0
                    sword_ctr_reg <= sword_ctr_reg + 2'd1;
                    if (sword_ctr_reg == 2'd3) begin
                        state <= (round_ctr != 4'd0) ? S_MAIN : S_FINAL;
                    end
                end
                S_MAIN: begin
                    round_ctr <= round_ctr - 4'd1;
                    state     <= S_SHIFT;
                end
                S_FINAL: begin
                    ready_reg <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath operation select decoded from the current state
    always_comb begin
        update_type = UPD_NO_UPDATE;
        case (state)
            S_INIT:  update_type = UPD_INIT;
            S_SHIFT: update_type = UPD_SHIFT;
            S_SBOX:  update_type = UPD_SBOX;
            S_MAIN:  update_type = UPD_MAIN;
            S_FINAL: update_type = UPD_FINAL;
            default: update_type = UPD_NO_UPDATE;
        endcase
    end

    // round_ctr is 0 in FINAL and IDLE, so it drives the key address directly
    assign round_key_addr = round_ctr;
    assign sword_ctr      = sword_ctr_reg;
    assign block_we       = (state != S_IDLE);
    assign ready          = ready_reg;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// tb/tb_aes_decipher_ctrl.sv - directed self-checking bench for aes_decipher_ctrl
module tb_aes_decipher_ctrl;

    logic       clk;
    logic       reset;
    logic       next;
    logic       keylen;
    logic [3:0] round_key_addr;
    logic [2:0] update_type;
    logic [1:0] sword_ctr;
    logic       block_we;
    logic       ready;

    int errors = 0;
    int checks = 0;

    aes_decipher_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .next           (next),
        .keylen         (keylen),
        .round_key_addr (round_key_addr),
        .update_type    (update_type),
        .sword_ctr      (sword_ctr),
        .block_we       (block_we),
        .ready          (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one block and observe every busy cycle until ready returns
    task automatic run_op(input string tag, input logic kl, input bit noisy, input bit hold, input int nr);
        int low, n_init, n_shift, n_sbox, n_main, n_final, exp_addr;
        bit addr_ok, sword_ok, we_ok;
        low = 0; n_init = 0; n_shift = 0; n_sbox = 0; n_main = 0; n_final = 0;
        exp_addr = nr; addr_ok = 1; sword_ok = 1; we_ok = 1;
        next = 1'b1;
        keylen = kl;
        step();
        if (!hold) next = 1'b0;
        while (ready === 1'b0 && low < 200) begin
            if (block_we !== 1'b1) we_ok = 0;
            case (update_type)
                3'd1, 3'd4, 3'd5: begin
                    if (round_key_addr !== exp_addr[3:0]) addr_ok = 0;
                    exp_addr--;
                    if (update_type == 3'd1) n_init++;
                    if (update_type == 3'd4) n_main++;
                    if (update_type == 3'd5) n_final++;
                end
                3'd2: n_shift++;
                3'd3: begin
                    if (sword_ctr !== 2'(n_sbox % 4)) sword_ok = 0;
                    n_sbox++;
                end
                default: ;
            endcase
            if (noisy) begin
                next   = (low < 50) ? low[0] : 1'b0;
                keylen = low[1];
            end
            low++;
            step();
        end
        if (noisy) keylen = kl;
        check({tag, "_low_cycles"}, low, 1 + 6 * nr);
        check({tag, "_init"}, n_init, 1);
        check({tag, "_shift"}, n_shift, nr);
        check({tag, "_sbox"}, n_sbox, 4 * nr);
        check({tag, "_main"}, n_main, nr - 1);
        check({tag, "_final"}, n_final, 1);
        check({tag, "_addr_seq"}, addr_ok, 1);
        check({tag, "_sword_seq"}, sword_ok, 1);
        check({tag, "_we_busy"}, we_ok, 1);
        check({tag, "_idle_we"}, block_we, 0);
        check({tag, "_idle_type"}, update_type, 0);
        check({tag, "_idle_addr"}, round_key_addr, 0);
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        next = 1'b0;
        keylen = 1'b0;
        #12;
        check("rst_ready", ready, 1);
        check("rst_we", block_we, 0);
        check("rst_type", update_type, 0);
        check("rst_addr", round_key_addr, 0);
        check("rst_sword", sword_ctr, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        run_op("aes128", 1'b0, 1'b0, 1'b0, 10);
        step();
        run_op("aes256", 1'b1, 1'b0, 1'b0, 14);
        step();
        run_op("noisy128", 1'b0, 1'b1, 1'b0, 10);
        step();

        // next held high: one ready cycle, then a new op starts
        run_op("held", 1'b0, 1'b0, 1'b1, 10);
        check("held_ready_pulse", ready, 1);
        step();
        check("held_restart_ready", ready, 0);
        check("held_restart_type", update_type, 1);
        check("held_restart_addr", round_key_addr, 10);
        next = 1'b0;
        guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            guard++;
            step();
        end
        check("held_second_done", ready, 1);
        step();

        // Reset inside the SBOX run of the round keyed at address 5
        next = 1'b1;
        keylen = 1'b0;
        step();
        next = 1'b0;
        guard = 0;
        while (!(update_type == 3'd3 && round_key_addr == 4'd5) && guard < 100) begin
            guard++;
            step();
        end
        check("mid_found_sbox5", (update_type == 3'd3 && round_key_addr == 4'd5), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_we", block_we, 0);
        check("mid_rst_type", update_type, 0);
        check("mid_rst_addr", round_key_addr, 0);
        check("mid_rst_sword", sword_ctr, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        run_op("after_rst", 1'b0, 1'b0, 1'b0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
